cordic_twiddle_sched: RTL and testbench
=======================================

# cordic_twiddle_sched

Twiddle-rotation scheduler for the 256-point radix-2 DIT FFT. It sequences one frame of 128 lower-butterfly samples through the shared combinational 16-iteration CORDIC rotator and generates each sample's twiddle angle from an internal butterfly counter. It performs the quadrant pre-rotation the CORDIC cannot cover, compensates the CORDIC gain, and exposes valid/ready streams on both sides. It sits between the butterfly unit and the stage memory write-back.

## Interface
Parameters:
- None. Frame length (128), data width (16) and angle scale are fixed by the FFT.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches cfg_stage/cfg_inv; honoured only in IDLE
- cfg_stage  in  3  FFT stage s, 0..7
- cfg_inv  in  1  0 = forward (W = e^-jθ), 1 = inverse (e^+jθ)
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_re, in_im  in  16  signed Q1.15 sample
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_re, out_im  out  16  signed rotated sample, unity gain
- out_k  out  7  twiddle exponent used for this sample
- out_last  out  1  high with the 128th output of the frame
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse when the frame is fully drained

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start; clear the butterfly counter j.
  - RUN -> DRAIN on the 128th accepted input.
  - DRAIN -> IDLE when the pipeline holds no valid data; pulse done on that transition.
- start outside IDLE is ignored.
- Twiddle exponent: k = (j mod 2^s) << (7 - s). j counts 0..127 per accepted input.
- Angle units: 1/256 degree, matching the CORDIC table (45° = 11520).
- Quadrant fix applied when k >= 64, so the residual stays within about ±88.6°:
  - Forward: (x, y) -> (y, -x); kr = k - 64.
  - Inverse: (x, y) -> (-y, x); kr = k - 64.
  - k < 64: no pre-rotation; kr = k.
- Pre-scale: arithmetic shift right by 1 applied before the quadrant fix. Negation therefore cannot overflow.
- θ = -360·kr (forward) or +360·kr (inverse), 16-bit signed; range ±22680.
- Gain compensation on each CORDIC output component: p = v · 19898 (32-bit signed); result = p >>> 14, truncated toward -inf.
  - Saturate to [-32768, 32767].
  - Net gain ≈ 1.0 (the 0.5 pre-scale × CORDIC gain 1.6468 × 19898/2^14).
- out_k and out_last travel through the pipeline alongside the data.
- Reset values: in_ready 0, out_valid 0, out_re/out_im/out_k 0, out_last 0, busy 0, done 0, state IDLE, j 0. All pipeline valid bits are cleared.

## Timing
- Three-stage pipeline:
  - S1 register: pre-scaled, quadrant-fixed x/y, θ, k, last.
  - CORDIC combinational between S1 and S2; S2 registers its result.
  - S3 register: gain-compensated output.
- Latency: input accepted at edge N -> out_valid at edge N+3, with no stall.
- Advance enable: adv = !out_valid || out_ready. All stages shift together when adv is high; when adv is low every stage holds.
- in_ready = (state == RUN) && adv; combinational from out_ready.
- Full throughput: one sample per cycle while out_ready stays high.
- Pipeline bubbles propagate as invalid slots; out_valid only ever asserts for real samples.
- out_valid, once asserted, holds with stable data until out_ready is sampled high.
- The 128th accept and the DRAIN transition occur on the same edge; no 129th accept is possible.
- done asserts the cycle after the last output handshake completes. A start in the same cycle as done is ignored.
- rst high in any state: the frame is aborted and returns to reset values on the next edge. No done pulse is produced.

## Test plan
- Reset: hold rst for 2 cycles mid-RUN with 40 samples accepted -> all outputs at reset values, state IDLE, next frame starts with j = 0 and out_k = 0.
- Stage 0 identity: s = 0, 128 inputs of (16384, 0) -> all out_k = 0, outputs (16384 ±4, 0 ±4), out_last on #128, done one cycle later.
- Stage 7 angles (forward), input (16384, 0):
  - j = 32 -> k = 32, out (11585, -11585) ±4.
  - j = 64 -> k = 64, out (0, -16384) ±4.
  - j = 96 -> k = 96, out (-11585, -11585) ±4.
- Inverse mode: cfg_inv = 1, s = 7, j = 96, input (16384, 0) -> out (-11585, 11585) ±4.
- Backpressure: full-rate input; drop out_ready for 10 cycles mid-frame -> in_ready falls the same cycle, no sample lost or duplicated, order preserved, exactly 128 outputs.
- Full-scale input: (-32768, -32768) at k = 0 -> outputs saturate within [-32768, 32767]; no wrap to positive values.

Source files
------------

// File: rtl/cordic_twiddle_sched.sv
// Twiddle-rotation scheduler for the 256-point radix-2 DIT FFT: quadrant fix, shared
// 16-iteration CORDIC and gain compensation behind a 3-stage valid/ready pipeline.
module cordic_twiddle_sched (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         cfg_stage,
    input  logic               cfg_inv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_re,
    input  logic signed [15:0] in_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_re,
    output logic signed [15:0] out_im,
    output logic [6:0]         out_k,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int unsigned ITER = 16;
    localparam int unsigned GB   = 4;   // fractional guard bits on x/y inside the rotator
    localparam int unsigned XW   = 22;
    localparam int unsigned ZW   = 26;
    localparam logic signed [31:0] GAIN = 32'sd19898;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_n;
    logic [6:0] j_q;
    logic [2:0] stage_q;
    logic       inv_q;
    logic       adv, accept;

    // Pipeline registers
    logic               v1, v2;
    logic signed [15:0] x1, y1, th1;
    logic [6:0]         k1, k2;
    logic               last1, last2;
    logic signed [17:0] re2, im2;

    // Front end: twiddle exponent, pre-scale, quadrant fix, angle
    logic [7:0]         jmask;
    logic [6:0]         k_in, kr;
    logic signed [15:0] xs, ys, x_fix, y_fix, theta_in;
    logic [15:0]        theta_mag;

    always_comb begin
        jmask    = (8'd1 << stage_q) - 8'd1;
        k_in     = 7'(({1'b0, j_q} & jmask) << (3'd7 - stage_q));
        xs       = in_re >>> 1;
        ys       = in_im >>> 1;
        x_fix    = xs;
        y_fix    = ys;
        kr       = k_in;
        if (k_in[6]) begin
            kr = {1'b0, k_in[5:0]};
            if (inv_q) begin
                x_fix = -ys;
                y_fix = xs;
            end else begin
                x_fix = ys;
                y_fix = -xs;
            end
        end
        theta_mag = {9'd0, kr} * 16'd360;
        theta_in  = inv_q ? signed'(theta_mag) : -signed'(theta_mag);
    end

    // atan(2^-i) in 1/65536 degree: the 1/256-degree angle carries 8 extra fraction bits here
    function automatic logic signed [ZW-1:0] atan_tab(input int unsigned i);
        case (i)
            0:       atan_tab = 26'sd2949120;
            1:       atan_tab = 26'sd1740967;
            2:       atan_tab = 26'sd919879;
            3:       atan_tab = 26'sd466945;
            4:       atan_tab = 26'sd234379;
            5:       atan_tab = 26'sd117304;
            6:       atan_tab = 26'sd58666;
            7:       atan_tab = 26'sd29335;
            8:       atan_tab = 26'sd14668;
            9:       atan_tab = 26'sd7334;
            10:      atan_tab = 26'sd3667;
            11:      atan_tab = 26'sd1833;
            12:      atan_tab = 26'sd917;
            13:      atan_tab = 26'sd458;
            14:      atan_tab = 26'sd229;
            15:      atan_tab = 26'sd115;
            default: atan_tab = '0;
        endcase
    endfunction

    logic signed [XW-1:0] cx, cy, cx_n;
    logic signed [ZW-1:0] cz;
    logic signed [17:0]   c_re, c_im;

    always_comb begin
        cx   = {{(XW-16-GB){x1[15]}}, x1, {GB{1'b0}}};
        cy   = {{(XW-16-GB){y1[15]}}, y1, {GB{1'b0}}};
        cz   = {{(ZW-24){th1[15]}}, th1, 8'd0};
        cx_n = '0;
        for (int unsigned i = 0; i < ITER; i++) begin
            if (cz[ZW-1]) begin
                cx_n = cx + (cy >>> i);
                cy   = cy - (cx >>> i);
                cz   = cz + atan_tab(i);
            end else begin
                cx_n = cx - (cy >>> i);
                cy   = cy + (cx >>> i);
                cz   = cz - atan_tab(i);
            end
            cx = cx_n;
        end
        c_re = 18'(cx >>> GB);
        c_im = 18'(cy >>> GB);
    end

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'h7FFF;
        else if (v < -18'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

    logic signed [31:0] p_re, p_im;
    logic signed [17:0] q_re, q_im;

    always_comb begin
        p_re = signed'({{14{re2[17]}}, re2}) * GAIN;
        p_im = signed'({{14{im2[17]}}, im2}) * GAIN;
        q_re = 18'(p_re >>> 14);
        q_im = 18'(p_im >>> 14);
    end

    assign adv    = !out_valid || out_ready;
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0; x1 <= '0; y1 <= '0; th1 <= '0; k1 <= '0; last1 <= 1'b0;
            v2 <= 1'b0; re2 <= '0; im2 <= '0; k2 <= '0; last2 <= 1'b0;
            out_valid <= 1'b0; out_re <= '0; out_im <= '0; out_k <= '0; out_last <= 1'b0;
        end else if (adv) begin
            v1    <= accept;
            x1    <= x_fix;
            y1    <= y_fix;
            th1   <= theta_in;
            k1    <= k_in;
            last1 <= (j_q == 7'd127);
            v2    <= v1;
            re2   <= c_re;
            im2   <= c_im;
            k2    <= k1;
            last2 <= last1;
            out_valid <= v2;
            out_re    <= sat16(q_re);
            out_im    <= sat16(q_im);
            out_k     <= k2;
            out_last  <= last2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            j_q     <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                j_q     <= '0;
                stage_q <= cfg_stage;
                inv_q   <= cfg_inv;
            end else if (accept) begin
                j_q <= j_q + 7'd1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        done     = 1'b0;
        busy     = (state != IDLE);
        in_ready = (state == RUN) && adv;
        case (state)
            IDLE:  if (start) state_n = RUN;
            RUN:   if (accept && j_q == 7'd127) state_n = DRAIN;
            DRAIN: begin
                if (!v1 && !v2 && !out_valid) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cordic_twiddle_sched.sv
// Randomized bench for cordic_twiddle_sched, scored against a floating-point
// complex-rotation model of the twiddle multiply with saturation.
module tb_cordic_twiddle_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, cfg_inv, in_valid, in_ready;
    logic               out_valid, out_ready, out_last, busy, done;
    logic [2:0]         cfg_stage;
    logic signed [15:0] in_re, in_im, out_re, out_im;
    logic [6:0]         out_k;

    cordic_twiddle_sched dut (
        .clk(clk), .rst(rst), .start(start), .cfg_stage(cfg_stage), .cfg_inv(cfg_inv),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_k(out_k), .out_last(out_last), .busy(busy), .done(done)
    );

    int total = 0;
    int bad   = 0;
    int src_re[128];
    int src_im[128];
    int sent_re[$], sent_im[$], got_re[$], got_im[$], got_k[$], got_last[$];
    int first_acc_cyc, first_out_cyc, last_out_cyc, done_cyc, done_count, stall_viol, hold_viol;

    function automatic int model_k(int j, int s);
        return (j % (1 << s)) * (1 << (7 - s));
    endfunction

    // x + jy multiplied by exp(-+j*2*pi*k/256), rounded and clamped to 16 bits
    function automatic int model_out(int x, int y, int k, bit inv, bit want_im);
        real a, r;
        int  v;
        a = (inv ? 1.0 : -1.0) * 6.283185307179586 * k / 256.0;
        r = want_im ? (x * $sin(a) + y * $cos(a)) : (x * $cos(a) - y * $sin(a));
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    function automatic bit near(int a, int b, int tol);
        return (a - b <= tol) && (b - a <= tol);
    endfunction

    // vmode 0: in_valid always; 1: random. rmode 0: ready always; 1: 10-cycle stall; 2: random
    task automatic run_frame(input int s, input bit inv, input int vmode, input int rmode,
                             input int stall_at);
        int cyc, n_in, prev_re, prev_im, prev_k;
        bit done_seen, prev_hold;
        sent_re.delete(); sent_im.delete();
        got_re.delete(); got_im.delete(); got_k.delete(); got_last.delete();
        first_acc_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; done_cyc = -1;
        done_count = 0; stall_viol = 0; hold_viol = 0;
        prev_re = 0; prev_im = 0; prev_k = 0;
        cfg_stage = 3'(s);
        cfg_inv   = inv;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; n_in = 0; done_seen = 1'b0; prev_hold = 1'b0;
        while (!done_seen && cyc < 3000) begin
            in_valid = (n_in < 128) && (vmode == 0 || $urandom_range(0, 3) != 0);
            in_re    = 16'(src_re[n_in < 128 ? n_in : 0]);
            in_im    = 16'(src_im[n_in < 128 ? n_in : 0]);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(cyc >= stall_at && cyc < stall_at + 10);
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clk);
            if (prev_hold && (out_valid !== 1'b1 || int'(out_re) != prev_re ||
                              int'(out_im) != prev_im || int'(out_k) != prev_k))
                hold_viol++;
            prev_hold = out_valid && !out_ready;
            prev_re = int'(out_re); prev_im = int'(out_im); prev_k = int'(out_k);
            if (out_valid && !out_ready && in_ready) stall_viol++;
            if (in_valid && in_ready) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                sent_re.push_back(src_re[n_in]);
                sent_im.push_back(src_im[n_in]);
                n_in++;
            end
            if (out_valid && out_ready) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                got_re.push_back(int'(out_re));
                got_im.push_back(int'(out_im));
                got_k.push_back(int'(out_k));
                got_last.push_back(int'(out_last));
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                done_count++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        int n, cyc;
        logic [43:0] rv;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rv = {in_ready, out_valid, out_re, out_im, out_k, out_last, busy, done};
        total++;
        if (rv !== 44'd0) begin bad++; $display("FAIL reset_init got=%h want=0", rv); end
        rst = 1'b0;
        @(posedge clk); #1;
        cfg_stage = 3'd7; cfg_inv = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 40 && cyc < 200) begin
            in_valid = 1'b1;
            in_re = 16'($urandom_range(0, 4000));
            in_im = 16'($urandom_range(0, 4000));
            @(negedge clk);
            if (in_valid && in_ready) n++;
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (n != 40) begin bad++; $display("FAIL reset_prefill got=%0d want=40", n); end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        rv = {in_ready, out_valid, out_re, out_im, out_k, out_last, busy, done};
        total++;
        if (rv !== 44'd0) begin bad++; $display("FAIL reset_midrun got=%h want=0", rv); end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 128; i++) begin
            src_re[i] = int'($urandom_range(0, 20000)) - 10000;
            src_im[i] = int'($urandom_range(0, 20000)) - 10000;
        end
        run_frame(7, 1'b0, 0, 0, 0);
        total++;
        if (got_k.size() != 128) begin
            bad++; $display("FAIL reset_next_count got=%0d want=128", got_k.size());
        end
        for (int i = 0; i < 3 && i < got_k.size(); i++) begin
            total++;
            if (got_k[i] != i) begin bad++; $display("FAIL reset_next_k[%0d] got=%0d want=%0d", i, got_k[i], i); end
        end
    endtask

    task automatic test_stage0_identity();
        for (int i = 0; i < 128; i++) begin src_re[i] = 16384; src_im[i] = 0; end
        run_frame(0, 1'b0, 0, 0, 0);
        total++;
        if (got_re.size() != 128) begin bad++; $display("FAIL s0_count got=%0d want=128", got_re.size()); end
        total++;
        if (first_out_cyc - first_acc_cyc != 3) begin
            bad++; $display("FAIL s0_latency got=%0d want=3", first_out_cyc - first_acc_cyc);
        end
        for (int i = 0; i < got_re.size() && i < 128; i++) begin
            total++;
            if (got_k[i] != 0 || !near(got_re[i], 16384, 4) || !near(got_im[i], 0, 4) ||
                got_last[i] != (i == 127 ? 1 : 0)) begin
                bad++;
                $display("FAIL s0_out[%0d] got=(%0d,%0d) k=%0d last=%0d want=(16384,0) k=0 last=%0d",
                         i, got_re[i], got_im[i], got_k[i], got_last[i], (i == 127 ? 1 : 0));
            end
        end
        total++;
        if (done_cyc != last_out_cyc + 1 || done_count != 1) begin
            bad++; $display("FAIL s0_done got_cyc=%0d want_cyc=%0d", done_cyc, last_out_cyc + 1);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL s0_idle got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_stage7_angles();
        int want_re[3] = '{11585, 0, -11585};
        int want_im[3] = '{-11585, -16384, -11585};
        for (int i = 0; i < 128; i++) begin src_re[i] = 16384; src_im[i] = 0; end
        run_frame(7, 1'b0, 0, 0, 0);
        total++;
        if (got_re.size() != 128) begin bad++; $display("FAIL s7_count got=%0d want=128", got_re.size()); end
        if (got_re.size() == 128) begin
            for (int n = 0; n < 3; n++) begin
                total++;
                if (got_k[32 + 32 * n] != 32 + 32 * n || !near(got_re[32 + 32 * n], want_re[n], 4) ||
                    !near(got_im[32 + 32 * n], want_im[n], 4)) begin
                    bad++;
                    $display("FAIL s7_j%0d got=(%0d,%0d) k=%0d want=(%0d,%0d) k=%0d", 32 + 32 * n,
                             got_re[32 + 32 * n], got_im[32 + 32 * n], got_k[32 + 32 * n],
                             want_re[n], want_im[n], 32 + 32 * n);
                end
            end
        end
        for (int i = 0; i < got_re.size() && i < 128; i++) begin
            total++;
            if (!near(got_re[i], model_out(16384, 0, i, 1'b0, 1'b0), 4) ||
                !near(got_im[i], model_out(16384, 0, i, 1'b0, 1'b1), 4)) begin
                bad++;
                $display("FAIL s7_model[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, got_re[i], got_im[i],
                         model_out(16384, 0, i, 1'b0, 1'b0), model_out(16384, 0, i, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_inverse();
        for (int i = 0; i < 128; i++) begin src_re[i] = 16384; src_im[i] = 0; end
        run_frame(7, 1'b1, 0, 0, 0);
        total++;
        if (got_re.size() != 128) begin bad++; $display("FAIL inv_count got=%0d want=128", got_re.size()); end
        if (got_re.size() == 128) begin
            total++;
            if (got_k[96] != 96 || !near(got_re[96], -11585, 4) || !near(got_im[96], 11585, 4)) begin
                bad++;
                $display("FAIL inv_j96 got=(%0d,%0d) k=%0d want=(-11585,11585) k=96",
                         got_re[96], got_im[96], got_k[96]);
            end
            total++;
            if (!near(got_re[32], 11585, 4) || !near(got_im[32], 11585, 4)) begin
                bad++; $display("FAIL inv_j32 got=(%0d,%0d) want=(11585,11585)", got_re[32], got_im[32]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 128; i++) begin
            src_re[i] = int'($urandom_range(0, 40000)) - 20000;
            src_im[i] = int'($urandom_range(0, 40000)) - 20000;
        end
        run_frame(5, 1'b0, 0, 1, 40);
        total++;
        if (got_re.size() != 128 || sent_re.size() != 128) begin
            bad++; $display("FAIL bp_count got=%0d sent=%0d want=128", got_re.size(), sent_re.size());
        end
        total++;
        if (stall_viol != 0) begin bad++; $display("FAIL bp_in_ready got=%0d want=0", stall_viol); end
        total++;
        if (hold_viol != 0) begin bad++; $display("FAIL bp_hold got=%0d want=0", hold_viol); end
        for (int i = 0; i < got_re.size() && i < sent_re.size(); i++) begin
            total++;
            if (got_k[i] != model_k(i, 5) ||
                !near(got_re[i], model_out(sent_re[i], sent_im[i], model_k(i, 5), 1'b0, 1'b0), 6) ||
                !near(got_im[i], model_out(sent_re[i], sent_im[i], model_k(i, 5), 1'b0, 1'b1), 6)) begin
                bad++;
                $display("FAIL bp_out[%0d] got=(%0d,%0d) k=%0d want=(%0d,%0d) k=%0d", i,
                         got_re[i], got_im[i], got_k[i],
                         model_out(sent_re[i], sent_im[i], model_k(i, 5), 1'b0, 1'b0),
                         model_out(sent_re[i], sent_im[i], model_k(i, 5), 1'b0, 1'b1), model_k(i, 5));
            end
        end
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < 128; i++) begin src_re[i] = -32768; src_im[i] = -32768; end
        run_frame(0, 1'b0, 0, 0, 0);
        total++;
        if (got_re.size() != 128) begin bad++; $display("FAIL fs_count got=%0d want=128", got_re.size()); end
        for (int i = 0; i < got_re.size() && i < 128; i += 16) begin
            total++;
            if (!near(got_re[i], -32768, 4) || !near(got_im[i], -32768, 4)) begin
                bad++; $display("FAIL fs_out[%0d] got=(%0d,%0d) want=(-32768,-32768)", i, got_re[i], got_im[i]);
            end
        end
    endtask

    task automatic test_random_frames();
        int s;
        bit inv;
        for (int f = 0; f < 3; f++) begin
            s   = int'($urandom_range(0, 7));
            inv = 1'($urandom_range(0, 1));
            for (int i = 0; i < 128; i++) begin
                src_re[i] = int'($urandom_range(0, 60000)) - 30000;
                src_im[i] = int'($urandom_range(0, 60000)) - 30000;
            end
            run_frame(s, inv, 1, 2, 0);
            total++;
            if (got_re.size() != 128 || sent_re.size() != 128 || done_cyc != last_out_cyc + 1) begin
                bad++;
                $display("FAIL rnd%0d_frame got=%0d sent=%0d done_cyc=%0d want 128 128 %0d", f,
                         got_re.size(), sent_re.size(), done_cyc, last_out_cyc + 1);
            end
            total++;
            if (hold_viol != 0 || stall_viol != 0) begin
                bad++; $display("FAIL rnd%0d_flow got hold=%0d stall=%0d want 0 0", f, hold_viol, stall_viol);
            end
            for (int i = 0; i < got_re.size() && i < sent_re.size(); i++) begin
                total++;
                if (got_k[i] != model_k(i, s) || got_last[i] != (i == 127 ? 1 : 0) ||
                    !near(got_re[i], model_out(sent_re[i], sent_im[i], model_k(i, s), inv, 1'b0), 6) ||
                    !near(got_im[i], model_out(sent_re[i], sent_im[i], model_k(i, s), inv, 1'b1), 6)) begin
                    bad++;
                    $display("FAIL rnd%0d_out[%0d] s=%0d inv=%0d got=(%0d,%0d) k=%0d want=(%0d,%0d) k=%0d",
                             f, i, s, inv, got_re[i], got_im[i], got_k[i],
                             model_out(sent_re[i], sent_im[i], model_k(i, s), inv, 1'b0),
                             model_out(sent_re[i], sent_im[i], model_k(i, s), inv, 1'b1), model_k(i, s));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_stage = '0; cfg_inv = 1'b0;
        in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
        test_reset();
        test_stage0_identity();
        test_stage7_angles();
        test_inverse();
        test_backpressure();
        test_full_scale();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
